// File: rtl/sb_tx_framer_if.sv
// Handshake bundle between the sideband TX framer, its message encoders and the SB serializer.
// A message or word moves only on a cycle where valid && ready; valid and payload hold until then.
interface sb_tx_framer_if;
    logic        msg_valid;
    logic        msg_ready;
    logic [63:0] msg_header;
    logic [63:0] msg_data;
    logic        ser_valid;
    logic        ser_ready;
    logic [63:0] ser_data;

    modport master (
        output msg_valid, msg_header, msg_data, ser_ready,
        input  msg_ready, ser_valid, ser_data
    );

    modport slave (
        input  msg_valid, msg_header, msg_data, ser_ready,
        output msg_ready, ser_valid, ser_data
    );
endinterface

// File: rtl/sb_tx_framer.sv
// Sideband TX framer: start/training pattern, CP/DP insertion, header/data framing and idle gap.
// Optional SB_TX_PARITY_INJECT_EN adds i_inject_cp_err / i_inject_dp_err for RX parity-error tests.
module sb_tx_framer #(
    parameter int MIN_PATTERN_REPS = 4,
    parameter int POST_DETECT_REPS = 4,
    parameter int GAP_CYCLES       = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_start_pattern,
    input  logic                 i_rx_pattern_detected,
    output logic                 o_pattern_done,
`ifdef SB_TX_PARITY_INJECT_EN
    input  logic                 i_inject_cp_err,
    input  logic                 i_inject_dp_err,
`endif
    sb_tx_framer_if.slave        bus,
    output logic                 o_msg_sent,
    output logic                 o_busy,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PATTERN = 3'd1,
        S_READY   = 3'd2,
        S_HEADER  = 3'd3,
        S_DATA    = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    localparam logic [63:0] PATTERN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [3:0]  MIN_REPS     = 4'(MIN_PATTERN_REPS);
    localparam logic [3:0]  POST_REPS    = 4'(POST_DETECT_REPS);
    localparam logic [3:0]  GAP_LAST     = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  rep_cnt_q, rep_cnt_d;
    logic [3:0]  post_cnt_q, post_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        det_q, det_d;
    logic [63:0] hdr_q, hdr_d;
    logic [63:0] data_q, data_d;
    logic        has_data_q, has_data_d;
    logic        pattern_done_q, pattern_done_d;

    logic xfer, has_data_in, cp, dp, inj_cp, inj_dp;
    logic unused_hdr_bits;

`ifdef SB_TX_PARITY_INJECT_EN
    assign inj_cp = i_inject_cp_err;
    assign inj_dp = i_inject_dp_err;
`else
    assign inj_cp = 1'b0;
    assign inj_dp = 1'b0;
`endif

    // Header bits [63:62] are replaced by {DP, CP} so the RX sees even parity.
    assign unused_hdr_bits = ^bus.msg_header[63:62];
    assign xfer        = bus.ser_valid && bus.ser_ready;
    assign has_data_in = (bus.msg_header[4:0] == 5'b11011);
    assign cp          = (^bus.msg_header[61:0]) ^ inj_cp;
    assign dp          = has_data_in & ((^bus.msg_data) ^ inj_dp);

    always_comb begin
        bus.ser_valid = 1'b0;
        bus.ser_data  = '0;
        unique case (state_q)
            S_PATTERN: begin bus.ser_valid = 1'b1; bus.ser_data = PATTERN_WORD; end
            S_HEADER:  begin bus.ser_valid = 1'b1; bus.ser_data = hdr_q;        end
            S_DATA:    begin bus.ser_valid = 1'b1; bus.ser_data = data_q;       end
            default:   ;
        endcase
    end

    assign bus.msg_ready   = (state_q == S_READY);
    assign o_busy          = !((state_q == S_IDLE) || (state_q == S_READY));
    assign o_msg_sent      = xfer && !i_flush &&
                             (((state_q == S_HEADER) && !has_data_q) || (state_q == S_DATA));
    assign o_pattern_done  = pattern_done_q;
    assign o_dbg_state     = state_q;

    always_comb begin
        state_d        = state_q;
        rep_cnt_d      = rep_cnt_q;
        post_cnt_d     = post_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        det_d          = det_q;
        hdr_d          = hdr_q;
        data_d         = data_q;
        has_data_d     = has_data_q;
        pattern_done_d = 1'b0;

        if (i_flush) begin
            state_d    = S_IDLE;
            rep_cnt_d  = '0;
            post_cnt_d = '0;
            gap_cnt_d  = '0;
            det_d      = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start_pattern) begin
                        state_d    = S_PATTERN;
                        rep_cnt_d  = '0;
                        post_cnt_d = '0;
                        det_d      = 1'b0;
                    end else if (bus.msg_valid) begin
                        state_d = S_READY;
                    end
                end
                S_PATTERN: begin
                    if (xfer && (rep_cnt_q != 4'd15)) rep_cnt_d = rep_cnt_q + 4'd1;
                    // The word being accepted this cycle already counts toward the minimum.
                    if (i_rx_pattern_detected && (rep_cnt_d >= MIN_REPS)) det_d = 1'b1;
                    if (xfer && det_q) begin
                        post_cnt_d = post_cnt_q + 4'd1;
                        if (post_cnt_d == POST_REPS) begin
                            state_d        = S_READY;
                            pattern_done_d = 1'b1;
                            rep_cnt_d      = '0;
                            post_cnt_d     = '0;
                            det_d          = 1'b0;
                        end
                    end
                end
                S_READY: begin
                    if (bus.msg_valid) begin
                        hdr_d      = {dp, cp, bus.msg_header[61:0]};
                        data_d     = bus.msg_data;
                        has_data_d = has_data_in;
                        state_d    = S_HEADER;
                    end
                end
                S_HEADER, S_DATA: begin
                    if (xfer) begin
                        gap_cnt_d = '0;
                        if ((state_q == S_HEADER) && has_data_q) state_d = S_DATA;
                        else if (GAP_CYCLES == 0)                 state_d = S_READY;
                        else                                      state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = S_READY;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            rep_cnt_q      <= '0;
            post_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            det_q          <= 1'b0;
            hdr_q          <= '0;
            data_q         <= '0;
            has_data_q     <= 1'b0;
            pattern_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rep_cnt_q      <= rep_cnt_d;
            post_cnt_q     <= post_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            det_q          <= det_d;
            hdr_q          <= hdr_d;
            data_q         <= data_d;
            has_data_q     <= has_data_d;
            pattern_done_q <= pattern_done_d;
        end
    end

endmodule

// File: tb/tb_sb_tx_framer.sv
// Directed bench for sb_tx_framer with default parameters (MIN=4, POST=4, GAP=2).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sb_tx_framer;

    localparam logic [2:0]  ST_IDLE    = 3'd0;
    localparam logic [2:0]  ST_PATTERN = 3'd1;
    localparam logic [2:0]  ST_READY   = 3'd2;
    localparam logic [2:0]  ST_DATA    = 3'd4;
    localparam logic [2:0]  ST_GAP     = 3'd5;
    localparam logic [63:0] PAT        = 64'hAAAA_AAAA_AAAA_AAAA;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_flush = 1'b0;
    logic       i_start_pattern = 1'b0;
    logic       i_rx_pattern_detected = 1'b0;
    logic       o_pattern_done;
    logic       o_msg_sent;
    logic       o_busy;
    logic [2:0] o_dbg_state;
`ifdef SB_TX_PARITY_INJECT_EN
    logic       i_inject_cp_err = 1'b0;
    logic       i_inject_dp_err = 1'b0;
`endif

    sb_tx_framer_if bus_if();

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    sb_tx_framer dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_flush               (i_flush),
        .i_start_pattern       (i_start_pattern),
        .i_rx_pattern_detected (i_rx_pattern_detected),
        .o_pattern_done        (o_pattern_done),
`ifdef SB_TX_PARITY_INJECT_EN
        .i_inject_cp_err       (i_inject_cp_err),
        .i_inject_dp_err       (i_inject_dp_err),
`endif
        .bus                   (bus_if),
        .o_msg_sent            (o_msg_sent),
        .o_busy                (o_busy),
        .o_dbg_state           (o_dbg_state)
    );

    task automatic tick();
        @(negedge i_clk);
    endtask

    // Presents a message and returns on the falling edge just after it was accepted.
    task automatic drive_msg(input logic [63:0] hdr, input logic [63:0] dat);
        bus_if.msg_header = hdr;
        bus_if.msg_data   = dat;
        bus_if.msg_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus_if.msg_ready) break;
            tick();
        end
        checks++;
        if (bus_if.msg_ready !== 1'b1) begin
            errors++;
            $display("FAIL msg_accept_timeout: msg_ready=%b required 1", bus_if.msg_ready);
        end
        tick();
        bus_if.msg_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.msg_valid  = 1'b0;
        bus_if.msg_header = '0;
        bus_if.msg_data   = '0;
        bus_if.ser_ready  = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b0 || bus_if.ser_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_ser: valid=%b data=%h required 0/0", bus_if.ser_valid, bus_if.ser_data);
        end
        checks++;
        if (bus_if.msg_ready !== 1'b0 || o_pattern_done !== 1'b0 || o_msg_sent !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b done=%b sent=%b busy=%b required 0000",
                     bus_if.msg_ready, o_pattern_done, o_msg_sent, o_busy);
        end
        tick(); tick();
        i_rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (o_dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", o_dbg_state, ST_IDLE);
        end
        tick();
    endtask

    task automatic test_pattern();
        int  words = 0;
        bit  done_seen = 0;
        bus_if.ser_ready = 1'b1;
        i_start_pattern  = 1'b1;
        tick();
        i_start_pattern  = 1'b0;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            i_rx_pattern_detected = (words >= 1);
            #1;
            if (o_pattern_done) begin
                done_seen = 1;
                checks++;
                if (o_dbg_state !== ST_READY || bus_if.msg_ready !== 1'b1 || bus_if.ser_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL pattern_exit: state=%0d ready=%b valid=%b required %0d/1/0",
                             o_dbg_state, bus_if.msg_ready, bus_if.ser_valid, ST_READY);
                end
            end else if (bus_if.ser_valid && bus_if.ser_ready) begin
                words++;
                checks++;
                if (bus_if.ser_data !== PAT) begin
                    errors++;
                    $display("FAIL pattern_word: got %h required %h", bus_if.ser_data, PAT);
                end
            end
            tick();
        end
        i_rx_pattern_detected = 1'b0;
        checks++;
        if (!done_seen || words != 8) begin
            errors++;
            $display("FAIL pattern_count: done=%0d words=%0d required 1/8", done_seen, words);
        end
        #1;
        checks++;
        if (o_pattern_done !== 1'b0) begin
            errors++;
            $display("FAIL pattern_done_pulse: got %b required 0", o_pattern_done);
        end
        tick();
    endtask

    task automatic test_header_only();
        logic [63:0] hdrs [3] = '{64'h0000_0000_0028_0012, 64'h0000_0000_0000_0001, 64'hC000_0000_0000_0003};
        logic [63:0] exps [3] = '{64'h0000_0000_0028_0012, 64'h4000_0000_0000_0001, 64'h0000_0000_0000_0003};
        logic [63:0] exp;
        bus_if.ser_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            exp_q.push_back(exps[v]);
            drive_msg(hdrs[v], 64'hDEAD_BEEF_DEAD_BEEF);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== exp || o_msg_sent !== 1'b1) begin
                errors++;
                $display("FAIL hdr_only_word[%0d]: valid=%b data=%h sent=%b required 1/%h/1",
                         v, bus_if.ser_valid, bus_if.ser_data, o_msg_sent, exp);
            end
            tick();
            for (int g = 0; g < 2; g++) begin
                #1;
                checks++;
                if (bus_if.ser_valid !== 1'b0 || bus_if.msg_ready !== 1'b0 || o_dbg_state !== ST_GAP) begin
                    errors++;
                    $display("FAIL hdr_only_gap[%0d]: valid=%b ready=%b state=%0d required 0/0/%0d",
                             g, bus_if.ser_valid, bus_if.msg_ready, o_dbg_state, ST_GAP);
                end
                tick();
            end
            #1;
            checks++;
            if (bus_if.msg_ready !== 1'b1) begin
                errors++;
                $display("FAIL hdr_only_ready_after_gap: got %b required 1", bus_if.msg_ready);
            end
            tick();
        end
    endtask

    task automatic test_header_data();
        logic [63:0] hdrs  [3] = '{64'h0000_0000_0000_001B, 64'h0000_0000_0000_003B, 64'h0000_0000_0000_001B};
        logic [63:0] datas [3] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE};
        logic [63:0] ehdr  [3] = '{64'h8000_0000_0000_001B, 64'h4000_0000_0000_003B, 64'h8000_0000_0000_001B};
        logic [63:0] exp;
        logic        dp_seen;
        bus_if.ser_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            exp_q.push_back(ehdr[v]);
            exp_q.push_back(datas[v]);
            drive_msg(hdrs[v], datas[v]);
            #1;
            exp = exp_q.pop_front();
            dp_seen = bus_if.ser_data[63];
            checks++;
            if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== exp || o_msg_sent !== 1'b0) begin
                errors++;
                $display("FAIL hdr_data_header[%0d]: valid=%b data=%h sent=%b required 1/%h/0",
                         v, bus_if.ser_valid, bus_if.ser_data, o_msg_sent, exp);
            end
            checks++;
            if ((^bus_if.ser_data[62:0]) !== 1'b0) begin
                errors++;
                $display("FAIL hdr_data_cp_parity[%0d]: got %b required 0", v, ^bus_if.ser_data[62:0]);
            end
            tick();
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== exp || o_msg_sent !== 1'b1 || o_dbg_state !== ST_DATA) begin
                errors++;
                $display("FAIL hdr_data_data[%0d]: valid=%b data=%h sent=%b state=%0d required 1/%h/1/%0d",
                         v, bus_if.ser_valid, bus_if.ser_data, o_msg_sent, o_dbg_state, exp, ST_DATA);
            end
            checks++;
            if ((^{bus_if.ser_data, dp_seen}) !== 1'b0) begin
                errors++;
                $display("FAIL hdr_data_dp_parity[%0d]: got %b required 0", v, ^{bus_if.ser_data, dp_seen});
            end
            tick();
            #1;
            checks++;
            if (bus_if.ser_valid !== 1'b0) begin
                errors++;
                $display("FAIL hdr_data_gap[%0d]: valid=%b required 0", v, bus_if.ser_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp = 64'h4000_0000_0000_0007;
        bus_if.ser_ready = 1'b0;
        drive_msg(64'h0000_0000_0000_0007, 64'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== exp || o_msg_sent !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: valid=%b data=%h sent=%b required 1/%h/0",
                         i, bus_if.ser_valid, bus_if.ser_data, o_msg_sent, exp);
            end
            tick();
        end
        bus_if.ser_ready = 1'b1;
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== exp || o_msg_sent !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_xfer: valid=%b data=%h sent=%b required 1/%h/1",
                     bus_if.ser_valid, bus_if.ser_data, o_msg_sent, exp);
        end
        tick();
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b0 || o_dbg_state !== ST_GAP) begin
            errors++;
            $display("FAIL backpressure_no_dup: valid=%b state=%0d required 0/%0d",
                     bus_if.ser_valid, o_dbg_state, ST_GAP);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        int sent_cnt = 0;
        int first = -1;
        int second = -1;
        bus_if.ser_ready  = 1'b1;
        bus_if.msg_header = 64'h0000_0000_0000_0001;
        bus_if.msg_data   = 64'd0;
        bus_if.msg_valid  = 1'b1;
        for (int cyc = 0; cyc < 40 && sent_cnt < 2; cyc++) begin
            #1;
            if (bus_if.ser_valid && bus_if.ser_ready) begin
                checks++;
                if (bus_if.ser_data !== 64'h4000_0000_0000_0001) begin
                    errors++;
                    $display("FAIL b2b_word: got %h required %h", bus_if.ser_data, 64'h4000_0000_0000_0001);
                end
            end
            if (o_msg_sent) begin
                if (sent_cnt == 0) first = cyc;
                else second = cyc;
                sent_cnt++;
            end
            if (bus_if.msg_ready && bus_if.msg_valid) acc++;
            tick();
            if (acc == 2) bus_if.msg_valid = 1'b0;
        end
        bus_if.msg_valid = 1'b0;
        checks++;
        if (sent_cnt != 2 || (second - first) != 4) begin
            errors++;
            $display("FAIL b2b_spacing: sent=%0d spacing=%0d required 2/4", sent_cnt, second - first);
        end
    endtask

    task automatic test_flush();
        bus_if.ser_ready = 1'b1;
        drive_msg(64'h0000_0000_0000_001B, 64'h1234_5678_9ABC_DEF0);
        tick();
        bus_if.ser_ready = 1'b0;
        #1;
        checks++;
        if (o_dbg_state !== ST_DATA || bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== 64'h1234_5678_9ABC_DEF0) begin
            errors++;
            $display("FAIL flush_pre: state=%0d valid=%b data=%h required %0d/1/%h",
                     o_dbg_state, bus_if.ser_valid, bus_if.ser_data, ST_DATA, 64'h1234_5678_9ABC_DEF0);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b0 || o_dbg_state !== ST_IDLE || o_msg_sent !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_post: valid=%b state=%0d sent=%b busy=%b required 0/%0d/0/0",
                     bus_if.ser_valid, o_dbg_state, o_msg_sent, o_busy, ST_IDLE);
        end
        tick();
        bus_if.ser_ready = 1'b1;
        drive_msg(64'h0000_0000_0028_0012, 64'd0);
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b1 || bus_if.ser_data !== 64'h0000_0000_0028_0012 || o_msg_sent !== 1'b1) begin
            errors++;
            $display("FAIL flush_next_msg: valid=%b data=%h sent=%b required 1/%h/1",
                     bus_if.ser_valid, bus_if.ser_data, o_msg_sent, 64'h0000_0000_0028_0012);
        end
        tick();
    endtask

    task automatic test_priority();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_start_pattern   = 1'b1;
        bus_if.msg_valid  = 1'b1;
        bus_if.msg_header = 64'h0000_0000_0000_0001;
        tick();
        i_start_pattern  = 1'b0;
        bus_if.msg_valid = 1'b0;
        #1;
        checks++;
        if (o_dbg_state !== ST_PATTERN || bus_if.ser_data !== PAT || bus_if.msg_ready !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL priority_pattern_wins: state=%0d data=%h ready=%b busy=%b required %0d/%h/0/1",
                     o_dbg_state, bus_if.ser_data, bus_if.msg_ready, o_busy, ST_PATTERN, PAT);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        checks++;
        if (o_dbg_state !== ST_IDLE || bus_if.ser_valid !== 1'b0 || o_pattern_done !== 1'b0) begin
            errors++;
            $display("FAIL priority_flush_pattern: state=%0d valid=%b done=%b required %0d/0/0",
                     o_dbg_state, bus_if.ser_valid, o_pattern_done, ST_IDLE);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus_if.ser_ready = 1'b0;
        drive_msg(64'h0000_0000_0000_0007, 64'd0);
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: valid=%b required 1", bus_if.ser_valid);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.ser_valid !== 1'b0 || bus_if.ser_data !== 64'd0 || o_dbg_state !== ST_IDLE || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h state=%0d busy=%b required 0/0/%0d/0",
                     bus_if.ser_valid, bus_if.ser_data, o_dbg_state, o_busy, ST_IDLE);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

`ifdef SB_TX_PARITY_INJECT_EN
    task automatic test_parity_inject();
        logic [63:0] hdrs [4] = '{64'h0000_0000_0000_001B, 64'h0000_0000_0000_001B,
                                  64'h0000_0000_0000_001B, 64'h0000_0000_0028_0012};
        logic [63:0] exps [4] = '{64'hC000_0000_0000_001B, 64'h8000_0000_0000_001B,
                                  64'h0000_0000_0000_001B, 64'h0000_0000_0028_0012};
        logic        icp  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        idp  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        hasd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus_if.ser_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            i_inject_cp_err = icp[v];
            i_inject_dp_err = idp[v];
            drive_msg(hdrs[v], 64'h0000_0000_0000_0001);
            i_inject_cp_err = 1'b0;
            i_inject_dp_err = 1'b0;
            #1;
            checks++;
            if (bus_if.ser_data !== exps[v]) begin
                errors++;
                $display("FAIL inject_header[%0d]: got %h required %h", v, bus_if.ser_data, exps[v]);
            end
            checks++;
            if ((^bus_if.ser_data[62:0]) !== icp[v]) begin
                errors++;
                $display("FAIL inject_cp_parity[%0d]: got %b required %b", v, ^bus_if.ser_data[62:0], icp[v]);
            end
            tick();
            if (hasd[v]) tick();
            for (int g = 0; g < 3; g++) tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_header_only();
        test_header_data();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_priority();
        test_async_reset();
`ifdef SB_TX_PARITY_INJECT_EN
        test_parity_inject();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
